// File: rtl/instruction_loader_if.sv
// ----------------------------------------------------------------------------
// instruction_loader_if
// Bundles the boot loader's control inputs, upstream byte stream, instruction
// memory write port and status flags into one connection.
//   master : host / bench side. Drives start, base_addr, word_count,
//            byte_valid and byte_data. Observes byte_ready, the write port
//            and the status flags.
//   slave  : loader side. The directions are the mirror of master.
// ----------------------------------------------------------------------------
interface instruction_loader_if #(
  parameter int ADDR_W  = 32,
  parameter int COUNT_W = 16
) ();
  logic               start;
  logic [ADDR_W-1:0]  base_addr;
  logic [COUNT_W-1:0] word_count;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               wr_en;
  logic [15:0]        wr_data;
  logic [ADDR_W-1:0]  wr_addr;
  logic               busy;
  logic               done;
  logic               err;
  logic               cpu_hold;

  modport master (
    output start, base_addr, word_count, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_data, wr_addr, busy, done, err, cpu_hold
  );

  modport slave (
    input  start, base_addr, word_count, byte_valid, byte_data,
    output byte_ready, wr_en, wr_data, wr_addr, busy, done, err, cpu_hold
  );
endinterface

// File: rtl/instruction_loader.sv
// ----------------------------------------------------------------------------
// instruction_loader
// Boot-time program loader that sits in front of the instruction memory
// write port. It packs an upstream byte stream little-endian into 16-bit
// words and writes them to consecutive addresses starting at base_addr. It
// keeps the core held in reset until the load has finished.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   ldr      instruction_loader_if.slave, which carries:
//              start/base_addr/word_count  load request, sampled in IDLE
//              byte_valid/byte_data/byte_ready  byte stream (valid & ready)
//              wr_en/wr_data/wr_addr  instruction-memory write port
//              busy/done/err/cpu_hold  status
// All outputs are registered.
// ----------------------------------------------------------------------------
module instruction_loader #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 101,
  parameter int COUNT_W = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  instruction_loader_if.slave ldr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_LO = 3'd1,
    GET_HI = 3'd2,
    WRITE  = 3'd3,
    FIN    = 3'd4
  } state_t;

  // The range check uses one extra bit so that base_addr + word_count cannot wrap.
  typedef logic [ADDR_W:0] ext_t;
  localparam ext_t DEPTH_EXT = ext_t'(DEPTH);

  state_t             state_q, state_d;
  logic [7:0]         lo_q, lo_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic               err_q, err_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               byte_ready_q, wr_en_q, busy_q, done_q;
  logic               xfer_s;

  // Returns 1 when the last word of the load is at address DEPTH-1 or lower.
  function automatic logic load_fits(input logic [ADDR_W-1:0]  base,
                                     input logic [COUNT_W-1:0] cnt);
    ext_t end_s;
    end_s = ext_t'(base) + ext_t'(cnt);
    return (end_s <= DEPTH_EXT);
  endfunction

  assign xfer_s = ldr.byte_valid & byte_ready_q;

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    rem_d      = rem_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;
    cpu_hold_d = cpu_hold_q;
    case (state_q)
      IDLE: begin
        if (ldr.start) begin
          if (ldr.word_count == '0) begin
            state_d    = FIN;
            err_d      = 1'b0;
            cpu_hold_d = 1'b0;   // drops together with the done pulse
          end else if (!load_fits(ldr.base_addr, ldr.word_count)) begin
            err_d = 1'b1;        // rejected: cpu_hold is left as it was
          end else begin
            state_d    = GET_LO;
            wr_addr_d  = ldr.base_addr;
            rem_d      = ldr.word_count;
            err_d      = 1'b0;
            cpu_hold_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      GET_LO: begin
        if (xfer_s) begin
          lo_d    = ldr.byte_data;
          state_d = GET_HI;
        end else begin
          state_d = GET_LO;
        end
      end
      GET_HI: begin
        if (xfer_s) begin
          wr_data_d = {ldr.byte_data, lo_q};
          state_d   = WRITE;
        end else begin
          state_d = GET_HI;
        end
      end
      WRITE: begin
        // The address moves forward only after the strobe cycle, so it stays
        // stable from the GET_LO cycle through the wr_en cycle.
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        rem_d     = rem_q - COUNT_W'(1);
        if (rem_q == COUNT_W'(1)) begin
          state_d    = FIN;
          cpu_hold_d = 1'b0;
        end else begin
          state_d = GET_LO;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. The per-state strobes are decoded from the
  // next state, which keeps them registered and still aligned with the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lo_q         <= 8'd0;
      rem_q        <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= 16'd0;
      err_q        <= 1'b0;
      cpu_hold_q   <= 1'b1;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      rem_q        <= rem_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_q        <= err_d;
      cpu_hold_q   <= cpu_hold_d;
      byte_ready_q <= (state_d == GET_LO) || (state_d == GET_HI);
      wr_en_q      <= (state_d == WRITE);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == FIN);
    end
  end

  assign ldr.byte_ready = byte_ready_q;
  assign ldr.wr_en      = wr_en_q;
  assign ldr.wr_data    = wr_data_q;
  assign ldr.wr_addr    = wr_addr_q;
  assign ldr.busy       = busy_q;
  assign ldr.done       = done_q;
  assign ldr.err        = err_q;
  assign ldr.cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_instruction_loader.sv
// ----------------------------------------------------------------------------
// tb_instruction_loader
// Self-checking bench for instruction_loader. It runs the directed loads
// first and then a series of random ones. For each load, the expected
// outcome comes from the loader's rules:
//   - the range decision,
//   - word i at base+i holding {byte[2i+1], byte[2i]},
//   - the write one cycle after the high byte,
//   - done one cycle after the last write.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_loader;
  localparam int ADDR_W  = 32;
  localparam int COUNT_W = 16;
  localparam int DEPTH   = 101;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  instruction_loader_if #(.ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) ldr_if ();

  instruction_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ldr     (ldr_if.slave)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] src_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one load request starting at the current negedge. It streams the
  // bytes in src_q (random bytes are made if it is empty), collects the
  // writes and checks them against the expected outcome.
  //   mode 0: byte_valid always high; 1: 1-on/2-off; 2: random.
  //   inject_at > 0: pulse a conflicting start in that cycle.
  task automatic do_load(input string tag, input logic [31:0] base, input logic [15:0] cnt,
                         input int mode, input int inject_at);
    logic [7:0]  bytes[$];
    logic [31:0] obs_addr[$];
    logic [15:0] obs_data[$];
    int          obs_cyc[$];
    int          hi_cyc[$];
    logic [63:0] end_a;
    int          kind, cyc, nxfer, busy_cnt, done_cyc, limit, inj;
    logic        hold_start, hold_prev, hold_done, vld;

    end_a = 64'(base) + 64'(cnt);
    kind  = (cnt == 16'd0) ? 0 : ((end_a > 64'(DEPTH)) ? 1 : 2);
    if (kind == 2 && src_q.size() == 0)
      for (int i = 0; i < 2 * int'(cnt); i++) src_q.push_back(8'($urandom));
    if (kind != 2) src_q.delete();
    bytes = src_q;
    inj   = (kind == 2) ? inject_at : 0;

    hold_start           = ldr_if.cpu_hold;
    ldr_if.start         = 1'b1;
    ldr_if.base_addr     = base;
    ldr_if.word_count    = cnt;
    ldr_if.byte_valid    = 1'b0;
    cyc = 0; nxfer = 0; busy_cnt = 0; done_cyc = -1;
    hold_prev = 1'b1; hold_done = 1'b1;
    limit = (kind == 1) ? 8 : 100 + 40 * int'(cnt);

    while (done_cyc < 0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      ldr_if.start = (cyc == inj);
      if (cyc == inj) begin
        ldr_if.base_addr  = base + 32'd7;
        ldr_if.word_count = 16'd1;
      end
      if (ldr_if.wr_en) begin
        obs_addr.push_back(ldr_if.wr_addr);
        obs_data.push_back(ldr_if.wr_data);
        obs_cyc.push_back(cyc);
      end
      if (ldr_if.busy) busy_cnt++;
      if (ldr_if.done) begin
        done_cyc  = cyc;
        hold_done = ldr_if.cpu_hold;
      end else begin
        hold_prev = ldr_if.cpu_hold;
      end
      case (mode)
        0:       vld = 1'b1;
        1:       vld = (cyc % 3 == 1);
        default: vld = 1'($urandom_range(0, 1));
      endcase
      vld = vld && (src_q.size() > 0);
      ldr_if.byte_valid = vld;
      ldr_if.byte_data  = vld ? src_q[0] : 8'($urandom);
      if (vld && ldr_if.byte_ready) begin
        void'(src_q.pop_front());
        if (nxfer % 2 == 1) hi_cyc.push_back(cyc);
        nxfer++;
      end
    end
    ldr_if.start      = 1'b0;
    ldr_if.byte_valid = 1'b0;
    src_q.delete();

    check_eq({tag, ":nwr"}, 64'(obs_addr.size()), (kind == 2) ? 64'(cnt) : 64'd0);
    for (int i = 0; i < obs_addr.size() && i < int'(cnt); i++) begin
      check_eq({tag, ":addr"}, 64'(obs_addr[i]), 64'(base) + 64'(i));
      check_eq({tag, ":data"}, 64'(obs_data[i]), 64'({bytes[2*i+1], bytes[2*i]}));
      if (i < hi_cyc.size())
        check_eq({tag, ":wr_lat"}, 64'(obs_cyc[i]), 64'(hi_cyc[i] + 1));
    end
    case (kind)
      0: begin
        check_eq({tag, ":done_cyc"}, 64'(done_cyc), 64'd1);
        check_eq({tag, ":busy_cyc"}, 64'(busy_cnt), 64'd1);
        check_eq({tag, ":hold_done"}, 64'(hold_done), 64'd0);
        check_eq({tag, ":err"}, 64'(ldr_if.err), 64'd0);
      end
      1: begin
        check_eq({tag, ":no_done"}, 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq({tag, ":busy_cyc"}, 64'(busy_cnt), 64'd0);
        check_eq({tag, ":err"}, 64'(ldr_if.err), 64'd1);
        check_eq({tag, ":hold_kept"}, 64'(ldr_if.cpu_hold), 64'(hold_start));
      end
      default: begin
        check_eq({tag, ":done_seen"}, 64'(done_cyc >= 0), 64'd1);
        if (obs_cyc.size() > 0)
          check_eq({tag, ":done_lat"}, 64'(done_cyc), 64'(obs_cyc[obs_cyc.size()-1] + 1));
        check_eq({tag, ":hold_done"}, 64'(hold_done), 64'd0);
        check_eq({tag, ":hold_prev"}, 64'(hold_prev), 64'd1);
        check_eq({tag, ":err"}, 64'(ldr_if.err), 64'd0);
      end
    endcase
    @(negedge clk);
    check_eq({tag, ":idle_busy"}, 64'(ldr_if.busy), 64'd0);
    check_eq({tag, ":idle_done"}, 64'(ldr_if.done), 64'd0);
  endtask

  // Checks the output values while the loader is in reset or just after it.
  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ":byte_ready"}, 64'(ldr_if.byte_ready), 64'd0);
    check_eq({tag, ":wr_en"},      64'(ldr_if.wr_en),      64'd0);
    check_eq({tag, ":wr_data"},    64'(ldr_if.wr_data),    64'd0);
    check_eq({tag, ":wr_addr"},    64'(ldr_if.wr_addr),    64'd0);
    check_eq({tag, ":busy"},       64'(ldr_if.busy),       64'd0);
    check_eq({tag, ":done"},       64'(ldr_if.done),       64'd0);
    check_eq({tag, ":err"},        64'(ldr_if.err),        64'd0);
    check_eq({tag, ":cpu_hold"},   64'(ldr_if.cpu_hold),   64'd1);
  endtask

  // Starts a 3-word load at 0x20 and applies reset right after the first
  // word is written.
  task automatic reset_mid_load();
    logic [7:0] b[6];
    int         cyc, nx;
    logic       seen;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    ldr_if.start      = 1'b1;
    ldr_if.base_addr  = 32'h20;
    ldr_if.word_count = 16'd3;
    cyc = 0; nx = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      ldr_if.start = 1'b0;
      if (ldr_if.wr_en) begin
        seen = 1'b1;
        check_eq("rst:first_addr", 64'(ldr_if.wr_addr), 64'h20);
        check_eq("rst:first_data", 64'(ldr_if.wr_data), 64'({b[1], b[0]}));
      end else begin
        ldr_if.byte_valid = 1'b1;
        ldr_if.byte_data  = b[nx % 6];
        if (ldr_if.byte_ready) nx++;
      end
    end
    check_eq("rst:first_seen", 64'(seen), 64'd1);
    reset_n           = 1'b0;
    ldr_if.byte_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n           = 1'b0;
    ldr_if.start      = 1'b0;
    ldr_if.base_addr  = 32'd0;
    ldr_if.word_count = 16'd0;
    ldr_if.byte_valid = 1'b0;
    ldr_if.byte_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    src_q = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    do_load("t1", 32'h10, 16'd3, 0, 0);
    src_q = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    do_load("t2", 32'h10, 16'd3, 1, 0);
    do_load("t3_zero", 32'h5, 16'd0, 0, 0);
    do_load("t4_rej", 32'd100, 16'd2, 0, 0);
    do_load("t4_edge", 32'd99, 16'd2, 2, 0);
    do_load("rej_wrap", 32'hFFFF_FFFF, 16'd2, 0, 0);
    do_load("rej_maxcnt", 32'd0, 16'hFFFF, 0, 0);
    do_load("full_depth", 32'd0, 16'd101, 0, 0);
    reset_mid_load();
    do_load("t5_after", 32'h20, 16'd3, 2, 0);
    src_q = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    do_load("t6_inject", 32'h10, 16'd3, 1, 4);

    for (int k = 0; k < 25; k++) begin
      logic [31:0] rb;
      logic [15:0] rc;
      int          rm, ri;
      rc = 16'($urandom_range(0, 5));
      rb = 32'($urandom_range(0, 104));
      rm = $urandom_range(0, 2);
      ri = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
      do_load("rnd", rb, rc, rm, ri);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
